// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input into a FIFO, serialised onto tx
// as START + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits (even parity, or odd when PARITY_ODD=1).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for a FIFO word
// S_START  | start bit (low) for one bit time
// S_DATA   | data bits, LSB first, one bit time each
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit(s) high; pops the next word at the end without a gap
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_t;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Pointers carry one extra MSB so a full FIFO differs from an empty one.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign full       = (count == FULL_CNT);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign push       = s_valid && !full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign s_ready    = !full;
  assign fifo_count = count;
  assign tick       = (timer_q == T_LAST);
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || !empty;

  // FIFO storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
  end

  // FIFO pointers; write and pop in the same cycle both advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Serializer state register; tx is registered to keep the pin glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Serializer next state, FIFO pop and line level.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != S_IDLE) timer_d = tick ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = '0;
          state_d   = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^head) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == D_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q == S_LAST) begin
            bit_cnt_d = '0;
            if (!empty) begin
              // Back-to-back frame: the next start bit follows immediately.
              pop     = 1'b1;
              shift_d = head;
              state_d = S_START;
`ifdef UART_TX_PARITY_EN
              parity_d = (^head) ^ (PARITY_ODD != 0);
`endif
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=4.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FM = 4 * (1 + 8 + P + 1);
  localparam int F7 = 4 * (1 + 7 + P + 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready, tx, busy;
  logic [4:0] fifo_count;

  logic [6:0] s7_data;
  logic       s7_valid;
  logic       s7_ready, tx7, busy7;
  logic [4:0] cnt7;

  int nvec = 0;
  int nmis = 0;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx(tx), .busy(busy), .fifo_count(fifo_count));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16), .PARITY_ODD(0)) dut7 (
    .clk(clk), .reset(reset), .s_data(s7_data), .s_valid(s7_valid), .s_ready(s7_ready),
    .tx(tx7), .busy(busy7), .fifo_count(cnt7));

`ifdef UART_TX_PARITY_EN
  logic [7:0] sp_data;
  logic       sp_valid;
  logic       pe_ready, tx_pe, busy_pe, po_ready, tx_po, busy_po;
  logic [4:0] cnt_pe, cnt_po;

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .reset(reset), .s_data(sp_data), .s_valid(sp_valid), .s_ready(pe_ready),
    .tx(tx_pe), .busy(busy_pe), .fifo_count(cnt_pe));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(1)) dut_po (
    .clk(clk), .reset(reset), .s_data(sp_data), .s_valid(sp_valid), .s_ready(po_ready),
    .tx(tx_po), .busy(busy_po), .fifo_count(cnt_po));
`endif

  // Expected line level at offset oo cycles into a frame (CLK_DIV=4).
  function automatic logic bit_at(int oo, logic [8:0] w, int nb, int has_par, logic par);
    int j;
    j = oo / 4;
    if (j == 0) return 1'b0;
    if (j <= nb) return w[j-1];
    if (has_par != 0 && j == nb + 1) return par;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 2000) begin
      step();
      g++;
    end
    nvec++;
    if (busy !== 1'b0) begin
      nmis++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, g);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    nvec++;
    if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || fifo_count !== 5'd0) begin
      nmis++;
      $display("FAIL reset_state: tx=%b busy=%b s_ready=%b count=%0d, required 1 0 1 0",
               tx, busy, s_ready, fifo_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic e;
    wait_idle();
    s_data = 8'h55;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    nvec++;
    if (fifo_count !== 5'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      nmis++;
      $display("FAIL single_write: count=%0d busy=%b tx=%b, required 1 1 1", fifo_count, busy, tx);
    end
    for (int c = 1; c <= FM + 1; c++) begin
      step();
      e = (c <= 1) ? 1'b1 : bit_at(c - 2, 9'h055, 8, P, 1'b0);
      nvec++;
      if (tx !== e) begin
        nmis++;
        $display("FAIL single_tx c=%0d: tx=%b, required %b", c, tx, e);
      end
      nvec++;
      if (busy !== (c <= FM)) begin
        nmis++;
        $display("FAIL single_busy c=%0d: busy=%b, required %b", c, busy, (c <= FM));
      end
      if (c == 1) begin
        nvec++;
        if (fifo_count !== 5'd0) begin
          nmis++;
          $display("FAIL single_pop: count=%0d, required 0", fifo_count);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [7:0] w;
    int o;
    wait_idle();
    s_data = 8'hA5;
    s_valid = 1'b1;
    step();
    s_data = 8'h3C;
    for (int c = 1; c <= 2 * FM + 1; c++) begin
      step();
      if (c == 1) s_valid = 1'b0;
      o = c - 2;
      w = (o < FM) ? 8'hA5 : 8'h3C;
      e = (c <= 1) ? 1'b1 : bit_at(o % FM, {1'b0, w}, 8, P, ^w);
      nvec++;
      if (tx !== e) begin
        nmis++;
        $display("FAIL b2b_tx c=%0d: tx=%b, required %b", c, tx, e);
      end
      nvec++;
      if (busy !== (c <= 2 * FM)) begin
        nmis++;
        $display("FAIL b2b_busy c=%0d: busy=%b, required %b", c, busy, (c <= 2 * FM));
      end
      nvec++;
      if (fifo_count !== ((c <= FM) ? 5'd1 : 5'd0)) begin
        nmis++;
        $display("FAIL b2b_count c=%0d: count=%0d, required %0d", c, fifo_count, (c <= FM) ? 1 : 0);
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] words [18];
    logic [7:0] rx;
    logic rdy;
    int idx, guard, gap;
    for (int i = 0; i < 18; i++) words[i] = 8'(i * 29) ^ 8'h5A;
    wait_idle();
    s_data = words[0];
    s_valid = 1'b1;
    step();
    idx = 1;
    guard = 0;
    while (idx <= 16 && guard < 40) begin
      s_data = words[idx];
      rdy = s_ready;
      step();
      if (rdy) idx++;
      guard++;
    end
    nvec++;
    if (idx != 17) begin
      nmis++;
      $display("FAIL full_accept: accepted %0d words, required 16", idx - 1);
    end
    nvec++;
    if (fifo_count !== 5'd16 || s_ready !== 1'b0) begin
      nmis++;
      $display("FAIL full_state: count=%0d s_ready=%b, required 16 0", fifo_count, s_ready);
    end
    s_data = words[17];
    repeat (10) step();
    nvec++;
    if (fifo_count !== 5'd16 || s_ready !== 1'b0) begin
      nmis++;
      $display("FAIL full_hold: count=%0d s_ready=%b, required 16 0", fifo_count, s_ready);
    end
    guard = 0;
    while (s_ready !== 1'b1 && guard < 2 * FM) begin
      step();
      guard++;
    end
    nvec++;
    if (s_ready !== 1'b1 || fifo_count !== 5'd15 || tx !== 1'b1) begin
      nmis++;
      $display("FAIL full_pop: s_ready=%b count=%0d tx=%b, required 1 15 1", s_ready, fifo_count, tx);
    end
    step();
    s_valid = 1'b0;
    nvec++;
    if (fifo_count !== 5'd16 || s_ready !== 1'b0 || tx !== 1'b0) begin
      nmis++;
      $display("FAIL full_refill: count=%0d s_ready=%b tx=%b, required 16 0 0", fifo_count, s_ready, tx);
    end
    for (int f = 1; f <= 17; f++) begin
      if (f > 1) begin
        gap = 0;
        while (tx !== 1'b0 && gap < 20) begin
          step();
          gap++;
        end
        nvec++;
        if (gap != 2) begin
          nmis++;
          $display("FAIL full_gap f=%0d: start after %0d cycles, required 2", f, gap);
        end
      end
      step();
      step();
      nvec++;
      if (tx !== 1'b0) begin
        nmis++;
        $display("FAIL full_start f=%0d: tx=%b, required 0", f, tx);
      end
      rx = '0;
      for (int b = 0; b < 8; b++) begin
        repeat (4) step();
        rx[b] = tx;
      end
      nvec++;
      if (rx !== words[f]) begin
        nmis++;
        $display("FAIL full_data f=%0d: got %h, required %h", f, rx, words[f]);
      end
      if (P != 0) begin
        repeat (4) step();
        nvec++;
        if (tx !== ^words[f]) begin
          nmis++;
          $display("FAIL full_parity f=%0d: tx=%b, required %b", f, tx, ^words[f]);
        end
      end
      repeat (4) step();
      nvec++;
      if (tx !== 1'b1) begin
        nmis++;
        $display("FAIL full_stop f=%0d: tx=%b, required 1", f, tx);
      end
    end
    wait_idle();
    nvec++;
    if (fifo_count !== 5'd0) begin
      nmis++;
      $display("FAIL full_drain: count=%0d, required 0", fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    int highs;
    wait_idle();
    s_data = 8'h00;
    s_valid = 1'b1;
    step();
    step();
    s_valid = 1'b0;
    repeat (14) step();
    nvec++;
    if (tx !== 1'b0 || fifo_count !== 5'd1) begin
      nmis++;
      $display("FAIL midreset_pre: tx=%b count=%0d, required 0 1", tx, fifo_count);
    end
    reset = 1'b1;
    step();
    nvec++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || s_ready !== 1'b1) begin
      nmis++;
      $display("FAIL midreset_post: tx=%b busy=%b count=%0d s_ready=%b, required 1 0 0 1",
               tx, busy, fifo_count, s_ready);
    end
    reset = 1'b0;
    highs = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (tx === 1'b1 && busy === 1'b0) highs++;
    end
    nvec++;
    if (highs != 100) begin
      nmis++;
      $display("FAIL midreset_quiet: %0d of 100 cycles idle, required 100", highs);
    end
  endtask

  task automatic test_width7();
    logic e;
    s7_data = 7'h41;
    s7_valid = 1'b1;
    step();
    s7_valid = 1'b0;
    for (int c = 1; c <= F7 + 1; c++) begin
      step();
      e = (c <= 1) ? 1'b1 : bit_at(c - 2, 9'h041, 7, P, 1'b0);
      nvec++;
      if (tx7 !== e) begin
        nmis++;
        $display("FAIL w7_tx c=%0d: tx=%b, required %b", c, tx7, e);
      end
      nvec++;
      if (busy7 !== (c <= F7)) begin
        nmis++;
        $display("FAIL w7_busy c=%0d: busy=%b, required %b", c, busy7, (c <= F7));
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic ee, eo;
    sp_data = 8'h07;
    sp_valid = 1'b1;
    step();
    sp_valid = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      step();
      ee = (c <= 1) ? 1'b1 : bit_at(c - 2, 9'h007, 8, 1, 1'b1);
      eo = (c <= 1) ? 1'b1 : bit_at(c - 2, 9'h007, 8, 1, 1'b0);
      nvec++;
      if (tx_pe !== ee || tx_po !== eo) begin
        nmis++;
        $display("FAIL parity_tx c=%0d: even=%b odd=%b, required %b %b", c, tx_pe, tx_po, ee, eo);
      end
      nvec++;
      if (busy_pe !== (c <= 44) || busy_po !== (c <= 44)) begin
        nmis++;
        $display("FAIL parity_busy c=%0d: even=%b odd=%b, required %b", c, busy_pe, busy_po, (c <= 44));
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    s7_data = '0;
    s7_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    sp_data = '0;
    sp_valid = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_width7();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
